// File: rtl/huffman_stream_merger_pkg.sv
// Shared types and helpers for the Huffman stream merger.
//   DEFAULT_DATA_W : default payload width of one Huffman entry
//   huff_entry_t   : one FIFO entry, payload plus end-of-block marker
//   next_enabled() : next enabled channel after sel, ascending, wrapping
package huffman_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int MAX_CH         = 32;
    localparam int MAX_CH_W       = 5;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic                      done;
    } huff_entry_t;

    typedef logic [MAX_CH-1:0] ch_mask_t;

    // Returns the first enabled channel strictly after sel (wrapping ch-1 -> 0).
    // If no other channel is enabled, sel itself is returned.
    function automatic int next_enabled(input int sel, input ch_mask_t mask, input int ch);
        int idx;
        int result;
        result = sel;
        // Scan from the far end so the nearest enabled channel is written last.
        for (int k = MAX_CH - 1; k >= 1; k--) begin
            if (k < ch) begin
                idx = sel + k;
                if (idx >= ch) idx = idx - ch;
                if (mask[idx[MAX_CH_W-1:0]]) result = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/huffman_stream_merger_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n : clock, async active-low reset (pointers only)
//   wr_en      : write wr_data this cycle (caller guarantees room, or a same-cycle read)
//   full       : DEPTH entries stored
//   rd_en      : drop the head entry this cycle (caller guarantees !empty)
//   rd_data    : current head entry, valid whenever !empty
//   empty      : no entries stored
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // The extra MSB on each pointer distinguishes full from empty when the
    // address bits are equal.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; emptiness is defined by the pointers alone,
    // so clearing the array would only cost a reset net on every bit.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/huffman_stream_merger.sv
// Merges CH Huffman code streams into one stream, whole blocks at a time,
// in round-robin channel order. A block ends at an entry with done=1.
//   clk, rst_n : clock, async active-low reset
//   in_valid/in_data/in_done/in_ready : per-channel write side (in_ready = FIFO not full)
//   chan_mask  : channels taking part in round-robin, sampled at block boundaries
//   out_valid/out_data/out_done/out_ready : registered output with backpressure
//   ovf        : sticky per-channel overflow (entry offered while full)
//   blk_cnt    : completed blocks accepted downstream, wrapping
//   sel        : channel currently being served
module huffman_stream_merger
    import huffman_pkg::*;
#(
    parameter int CH     = 3,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH-1:0]          in_valid,
    input  logic [CH*DATA_W-1:0]   in_data,
    input  logic [CH-1:0]          in_done,
    output logic [CH-1:0]          in_ready,
    input  logic [CH-1:0]          chan_mask,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_done,
    input  logic                   out_ready,
    output logic [CH-1:0]          ovf,
    output logic [CNT_W-1:0]       blk_cnt,
    output logic [$clog2(CH)-1:0]  sel
);

    localparam int SEL_W = $clog2(CH);

    logic [CH-1:0]    fifo_full;
    logic [CH-1:0]    fifo_empty;
    logic [CH-1:0]    wr_en;
    logic [CH-1:0]    rd_en;
    logic [DATA_W:0]  head [CH];
    logic [DATA_W:0]  head_sel;
    logic             mid_block;
    logic             load_en;
    logic             pop;
    logic [SEL_W-1:0] next_sel;

    for (genvar i = 0; i < CH; i++) begin : g_fifo
        sync_fifo_fwft #(
            .WIDTH (DATA_W + 1),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[i]),
            .wr_data ({in_data[i*DATA_W +: DATA_W], in_done[i]}),
            .full    (fifo_full[i]),
            .rd_en   (rd_en[i]),
            .rd_data (head[i]),
            .empty   (fifo_empty[i])
        );
    end

    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rd_en    = '0;
        load_en  = !out_valid || out_ready;
        head_sel = head[sel];
        // The mask only gates the start of a block; a started block always finishes.
        pop      = load_en && !fifo_empty[sel] && (mid_block || chan_mask[sel]);
        rd_en[sel] = pop;
        next_sel = SEL_W'(next_enabled(int'(sel), ch_mask_t'(chan_mask), CH));
    end

    // A full FIFO still accepts a write in the cycle its head is popped.
    assign wr_en    = in_valid & (~fifo_full | rd_en);
    assign in_ready = ~fifo_full;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_done  <= 1'b0;
            sel       <= '0;
            mid_block <= 1'b0;
            ovf       <= '0;
            blk_cnt   <= '0;
        end else begin
            if (pop) begin
                {out_data, out_done} <= head_sel;
                out_valid            <= 1'b1;
                if (head_sel[0]) begin
                    mid_block <= 1'b0;
                    sel       <= next_sel;
                end else begin
                    mid_block <= 1'b1;
                end
            end else begin
                if (out_ready) out_valid <= 1'b0;
                // Idle on a disabled channel: seek to the next enabled one.
                if (!mid_block && !chan_mask[sel] && (|chan_mask)) sel <= next_sel;
            end

            if (out_valid && out_ready && out_done) blk_cnt <= blk_cnt + CNT_W'(1);

            ovf <= ovf | (in_valid & fifo_full & ~rd_en);
        end
    end

endmodule
